// File: rtl/reset_source_if.sv
// Reset-request bundle: button, watchdog and software sources in, reset request and status out.
interface reset_source_if;
  logic       btn_n;
  logic       soft_rst;
  logic       wdt_en;
  logic       wdt_kick;
  logic       rst_req_n;
  logic [1:0] rst_cause;
  logic       busy;
  logic       btn_deb_n;

  modport master (
    output btn_n, soft_rst, wdt_en, wdt_kick,
    input  rst_req_n, rst_cause, busy, btn_deb_n
  );

  modport slave (
    input  btn_n, soft_rst, wdt_en, wdt_kick,
    output rst_req_n, rst_cause, busy, btn_deb_n
  );
endinterface

// File: rtl/reset_source.sv
// Merges button, watchdog and software reset requests into one stretched active-low pulse
// with hold-while-pressed, cooldown before re-arming, and a recorded reset cause.
module reset_source #(
  parameter int unsigned DEB_W     = 16,
  parameter int unsigned WDT_W     = 24,
  parameter int unsigned PULSE_LEN = 16
) (
  input logic           clk,
  input logic           rst,
  reset_source_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ASSERT, HOLD, COOLDOWN} state_e;

  localparam logic [7:0] PULSE_LOAD = 8'(PULSE_LEN - 1);

  state_e           state_q, state_d;
  logic             sync1_q, sync2_q;
  logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;
  logic             btn_deb_q, btn_deb_d;
  logic [WDT_W-1:0] wdt_cnt_q, wdt_cnt_d;
  logic [7:0]       pulse_cnt_q, pulse_cnt_d;
  logic [1:0]       cause_q, cause_d;
  logic             rst_req_n_q, rst_req_n_d;
  logic             wdt_to;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      deb_cnt_q   <= '0;
      btn_deb_q   <= 1'b1;
      wdt_cnt_q   <= '0;
      pulse_cnt_q <= '0;
      cause_q     <= 2'b00;
      rst_req_n_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      sync1_q     <= bus.btn_n;
      sync2_q     <= sync1_q;
      deb_cnt_q   <= deb_cnt_d;
      btn_deb_q   <= btn_deb_d;
      wdt_cnt_q   <= wdt_cnt_d;
      pulse_cnt_q <= pulse_cnt_d;
      cause_q     <= cause_d;
      rst_req_n_q <= rst_req_n_d;
    end
  end

  // A new level is accepted only after it has differed from the debounced value for a full window.
  always_comb begin
    deb_cnt_d = '0;
    btn_deb_d = btn_deb_q;
    if (sync2_q != btn_deb_q) begin
      if (deb_cnt_q == '1) begin
        btn_deb_d = sync2_q;
      end else begin
        deb_cnt_d = deb_cnt_q + DEB_W'(1);
      end
    end
  end

  // A kick landing in the terminal cycle suppresses the timeout.
  always_comb begin
    wdt_to    = bus.wdt_en && (wdt_cnt_q == '1) && !bus.wdt_kick;
    wdt_cnt_d = wdt_cnt_q + WDT_W'(1);
    if (!bus.wdt_en || bus.wdt_kick || (state_q != IDLE)) begin
      wdt_cnt_d = '0;
    end
  end

  always_comb begin
    state_d     = state_q;
    pulse_cnt_d = pulse_cnt_q;
    cause_d     = cause_q;
    case (state_q)
      IDLE: begin
        if (!btn_deb_q) begin
          state_d     = ASSERT;
          pulse_cnt_d = PULSE_LOAD;
          cause_d     = 2'b01;
        end else if (wdt_to) begin
          state_d     = ASSERT;
          pulse_cnt_d = PULSE_LOAD;
          cause_d     = 2'b10;
        end else if (bus.soft_rst) begin
          state_d     = ASSERT;
          pulse_cnt_d = PULSE_LOAD;
          cause_d     = 2'b11;
        end
      end
      ASSERT: begin
        if (pulse_cnt_q == 8'd0) begin
          if (!btn_deb_q) begin
            state_d = HOLD;
          end else begin
            state_d     = COOLDOWN;
            pulse_cnt_d = PULSE_LOAD;
          end
        end else begin
          pulse_cnt_d = pulse_cnt_q - 8'd1;
        end
      end
      HOLD: begin
        if (btn_deb_q) begin
          state_d     = COOLDOWN;
          pulse_cnt_d = PULSE_LOAD;
        end
      end
      COOLDOWN: begin
        if (pulse_cnt_q == 8'd0) begin
          state_d = IDLE;
        end else begin
          pulse_cnt_d = pulse_cnt_q - 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    rst_req_n_d = !((state_d == ASSERT) || (state_d == HOLD));
  end

  assign bus.rst_req_n = rst_req_n_q;
  assign bus.rst_cause = cause_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.btn_deb_n = btn_deb_q;

endmodule
